// File: rtl/reg_transfer_sequencer.sv
// Transfer sequencer for a bank of bus-attached registers: accepts one command at a time and
// walks it through DRIVE/LATCH/DONE with registered oe/load/bus strobes.
module reg_transfer_sequencer #(
  parameter  int NREG = 8,
  parameter  int W    = 8,
  localparam int SELW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [SELW-1:0]   req_src,
  input  logic [SELW-1:0]   req_dst,
  input  logic [W-1:0]      req_imm,
  output logic [NREG-1:0]   reg_oe,
  output logic [NREG-1:0]   reg_load,
  output logic              bus_drive,
  output logic [W-1:0]      bus_out,
  input  logic [W-1:0]      bus_in,
  output logic [W-1:0]      rd_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_IMM  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  state_t          state_reg;
  logic [1:0]      op_reg;
  logic [NREG-1:0] dst_hot_reg;

  logic [NREG-1:0] src_hot;
  logic [NREG-1:0] dst_hot;
  logic            src_ok;
  logic            dst_ok;
  logic            uses_src;
  logic            uses_dst;
  logic            cmd_ok;

  // Index decode; an out-of-range index decodes to all-zero and is rejected below.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_decode
      assign src_hot[gi] = (int'(req_src) == gi);
      assign dst_hot[gi] = (int'(req_dst) == gi);
    end
  endgenerate

  assign src_ok   = (int'(req_src) < NREG);
  assign dst_ok   = (int'(req_dst) < NREG);
  assign uses_src = (req_op == OP_MOVE) || (req_op == OP_READ);
  assign uses_dst = (req_op == OP_MOVE) || (req_op == OP_IMM);
  assign cmd_ok   = (req_op != OP_RSVD) && (!uses_src || src_ok) && (!uses_dst || dst_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      op_reg      <= OP_MOVE;
      dst_hot_reg <= '0;
      req_ready   <= 1'b1;
      reg_oe      <= '0;
      reg_load    <= '0;
      bus_drive   <= 1'b0;
      bus_out     <= '0;
      rd_data     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid) begin
            op_reg      <= req_op;
            dst_hot_reg <= dst_hot;
            req_ready   <= 1'b0;
            if (cmd_ok) begin
              state_reg <= DRIVE;
              if (req_op == OP_IMM) begin
                bus_drive <= 1'b1;
                bus_out   <= req_imm;
              end else begin
                reg_oe <= src_hot;
              end
            end else begin
              state_reg <= DONE;
              done      <= 1'b1;
              err       <= 1'b1;
            end
          end
        end
        // Source has now driven for a full cycle, so the load strobe may follow.
        DRIVE: begin
          state_reg <= LATCH;
          if (op_reg != OP_READ) begin
            reg_load <= dst_hot_reg;
          end
        end
        LATCH: begin
          state_reg <= DONE;
          if (op_reg == OP_READ) begin
            rd_data <= bus_in;
          end
          reg_oe    <= '0;
          reg_load  <= '0;
          bus_drive <= 1'b0;
          bus_out   <= '0;
          done      <= 1'b1;
          err       <= 1'b0;
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed bench for reg_transfer_sequencer with a behavioural register bank on the shared bus.
module tb_reg_transfer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_src;
  logic [2:0] req_dst;
  logic [7:0] req_imm;
  logic [7:0] reg_oe;
  logic [7:0] reg_load;
  logic       bus_drive;
  logic [7:0] bus_out;
  logic [7:0] bus_val;
  logic [7:0] rd_data;
  logic       done;
  logic       err;

  logic       valid6;
  logic       ready6;
  logic [5:0] oe6;
  logic [5:0] load6;
  logic       drive6;
  logic [7:0] out6;
  logic [7:0] rd6;
  logic       done6;
  logic       err6;

  logic [7:0] bank [8];

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  reg_transfer_sequencer #(.NREG(8), .W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
    .reg_oe(reg_oe), .reg_load(reg_load), .bus_drive(bus_drive), .bus_out(bus_out),
    .bus_in(bus_val), .rd_data(rd_data), .done(done), .err(err)
  );

  reg_transfer_sequencer #(.NREG(6), .W(8)) dut6 (
    .clk(clk), .rst(rst), .req_valid(valid6), .req_ready(ready6),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
    .reg_oe(oe6), .reg_load(load6), .bus_drive(drive6), .bus_out(out6),
    .bus_in(8'h00), .rd_data(rd6), .done(done6), .err(err6)
  );

  // Shared bus: whichever source is enabled; register bank loads from it.
  always_comb begin
    bus_val = '0;
    if (bus_drive) bus_val = bus_out;
    for (int i = 0; i < 8; i++) begin
      if (reg_oe[i]) bus_val = bus_val | bank[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reg_load[i]) bank[i] <= bus_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("inv_oe_onehot", 32'(($countones(reg_oe) + int'(bus_drive)) <= 1), 1);
    chk("inv_load_onehot", 32'($countones(reg_load) <= 1), 1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d, input logic [7:0] imm);
    req_op = op; req_src = s; req_dst = d; req_imm = imm;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d, input logic [7:0] imm);
    issue(op, s, d, imm);
    tick(); tick(); tick();
  endtask

  initial begin
    int g;
    int prev;
    rst = 1'b1; req_valid = 1'b0; valid6 = 1'b0;
    req_op = 2'b00; req_src = '0; req_dst = '0; req_imm = '0;

    // Reset values
    tick(); tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_oe", reg_oe, 0);
    chk("rst_load", reg_load, 0);
    chk("rst_drive", bus_drive, 0);
    chk("rst_bus_out", bus_out, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready6", ready6, 1);
    rst = 1'b0;

    // IMM dst=0 imm=A5
    issue(2'b01, 3'd0, 3'd0, 8'hA5);
    chk("imm_t1_drive", bus_drive, 1);
    chk("imm_t1_bus_out", bus_out, 8'hA5);
    chk("imm_t1_oe", reg_oe, 0);
    chk("imm_t1_load", reg_load, 0);
    chk("imm_t1_ready", req_ready, 0);
    tick();
    chk("imm_t2_drive", bus_drive, 1);
    chk("imm_t2_load", reg_load, 8'h01);
    chk("imm_t2_oe", reg_oe, 0);
    tick();
    chk("imm_t3_done", done, 1);
    chk("imm_t3_err", err, 0);
    chk("imm_t3_drive", bus_drive, 0);
    chk("imm_t3_load", reg_load, 0);
    chk("imm_bank0", bank[0], 8'hA5);
    tick();
    chk("imm_idle_ready", req_ready, 1);
    chk("imm_idle_done", done, 0);

    // Preload registers through the sequencer
    run_cmd(2'b01, 3'd0, 3'd2, 8'h5A);
    run_cmd(2'b01, 3'd0, 3'd3, 8'h33);
    run_cmd(2'b01, 3'd0, 3'd7, 8'h3C);
    chk("preload_r2", bank[2], 8'h5A);
    chk("preload_r7", bank[7], 8'h3C);

    // MOVE src=2 dst=5
    issue(2'b00, 3'd2, 3'd5, 8'h00);
    chk("move_t1_oe", reg_oe, 8'h04);
    chk("move_t1_load", reg_load, 0);
    tick();
    chk("move_t2_oe", reg_oe, 8'h04);
    chk("move_t2_load", reg_load, 8'h20);
    chk("move_t2_done", done, 0);
    tick();
    chk("move_t3_done", done, 1);
    chk("move_t3_err", err, 0);
    chk("move_t3_oe", reg_oe, 0);
    chk("move_bank5", bank[5], 8'h5A);
    tick();

    // READ src=7
    issue(2'b10, 3'd7, 3'd0, 8'h00);
    chk("read_t1_oe", reg_oe, 8'h80);
    chk("read_t1_load", reg_load, 0);
    tick();
    chk("read_t2_oe", reg_oe, 8'h80);
    chk("read_t2_load", reg_load, 0);
    tick();
    chk("read_t3_done", done, 1);
    chk("read_rd_data", rd_data, 8'h3C);
    tick();
    chk("read_rd_hold", rd_data, 8'h3C);

    // MOVE src==dst leaves the value unchanged
    issue(2'b00, 3'd3, 3'd3, 8'h00);
    tick();
    chk("self_oe", reg_oe, 8'h08);
    chk("self_load", reg_load, 8'h08);
    tick(); tick();
    chk("self_bank3", bank[3], 8'h33);

    // Reserved opcode
    issue(2'b11, 3'd1, 3'd1, 8'hFF);
    chk("rsvd_done", done, 1);
    chk("rsvd_err", err, 1);
    chk("rsvd_oe", reg_oe, 0);
    chk("rsvd_load", reg_load, 0);
    chk("rsvd_drive", bus_drive, 0);
    chk("rsvd_rd_data", rd_data, 8'h3C);
    tick();
    chk("rsvd_ready", req_ready, 1);
    chk("rsvd_done_clear", done, 0);

    // NREG=6: dst=7 rejected, dst=5 accepted
    req_op = 2'b00; req_src = 3'd0; req_dst = 3'd7; req_imm = 8'h00;
    valid6 = 1'b1;
    tick();
    valid6 = 1'b0;
    chk("n6_bad_done", done6, 1);
    chk("n6_bad_err", err6, 1);
    chk("n6_bad_oe", oe6, 0);
    chk("n6_bad_load", load6, 0);
    tick();
    chk("n6_ready", ready6, 1);
    req_op = 2'b01; req_dst = 3'd5; req_imm = 8'h42;
    valid6 = 1'b1;
    tick();
    valid6 = 1'b0;
    chk("n6_imm_err", err6, 0);
    chk("n6_imm_done", done6, 0);
    chk("n6_imm_drive", drive6, 1);
    chk("n6_imm_out", out6, 8'h42);
    tick();
    chk("n6_imm_load", load6, 6'h20);
    tick();
    chk("n6_imm_done3", done6, 1);
    chk("n6_imm_err3", err6, 0);
    tick();

    // Reset during LATCH of a MOVE aborts it
    issue(2'b00, 3'd0, 3'd3, 8'h00);
    tick();
    chk("abort_latch_load", reg_load, 8'h08);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_oe", reg_oe, 0);
    chk("abort_load", reg_load, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_drive", bus_drive, 0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", done, 0);
      tick();
    end

    // Continuous req_valid: accepts spaced 4 cycles apart
    req_op = 2'b01; req_src = 3'd0; req_dst = 3'd1; req_imm = 8'h77;
    req_valid = 1'b1;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      while (!req_ready && g < 8) begin
        tick();
        g++;
      end
      chk("spacing_timeout", 32'(g < 8), 1);
      if (prev >= 0) chk("spacing", 32'(cyc - prev), 4);
      prev = cyc;
      tick();
    end
    req_valid = 1'b0;
    g = 0;
    while (!req_ready && g < 8) begin
      tick();
      g++;
    end
    chk("drain_timeout", 32'(g < 8), 1);

    // Random commands under the per-cycle invariant checks
    for (int k = 0; k < 30; k++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom));
      g = 0;
      while (!done && g < 6) begin
        tick();
        g++;
      end
      chk("rand_done_timeout", 32'(g < 6), 1);
      tick();
      chk("rand_ready", req_ready, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
